// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle unsigned multiply/divide execution unit that sits between the
// register file read ports and its write port. One operation in flight at a
// time; every operation takes a fixed W+1 cycles from issue to write-back.
//
// Ports:
//   Clk      rising-edge clock
//   Reset    synchronous reset, active low
//   Start    issue request, sampled only while Busy==0
//   Op       00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR
//   OpA      multiplicand / dividend
//   OpB      multiplier / divisor
//   Dest     destination register of the result
//   Busy     high from the cycle after an accepted Start through write-back
//   Wen      single-cycle register file write enable
//   Wd       write address (qualify with Wen)
//   Wdat     write data (qualify with Wen)
//   DivZero  sticky divide-by-zero flag, cleared by the next accepted Start
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    Op,
    input  logic [W-1:0]  OpA,
    input  logic [W-1:0]  OpB,
    input  logic [AW-1:0] Dest,
    output logic          Busy,
    output logic          Wen,
    output logic [AW-1:0] Wd,
    output logic [W-1:0]  Wdat,
    output logic          DivZero
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } state_t;

    state_t        r_state;
    logic [1:0]    r_op;
    logic [AW-1:0] r_dest;
    logic [CW-1:0] r_count;
    // Multiply and divide share one datapath:
    //   MUL: r_hi = running upper product, r_lo = multiplier shifting out /
    //        product low half shifting in, r_opnd = multiplicand
    //   DIV: r_hi = partial remainder, r_lo = dividend shifting out /
    //        quotient shifting in, r_opnd = divisor
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic [W-1:0]  r_opnd;

    logic [W:0]    w_mulSum;
    logic [W:0]    w_divShift;
    logic [W-1:0]  w_divDiff;
    logic          w_divFits;
    logic [W-1:0]  w_nextHi;
    logic [W-1:0]  w_nextLo;

    // One iteration of either algorithm. The division difference only needs
    // W bits because it is used only when the trial subtraction fits, and the
    // remainder is then always smaller than the divisor.
    always_comb begin
        w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_divShift = {r_hi, r_lo[W-1]};
        w_divDiff  = w_divShift[W-1:0] - r_opnd;
        w_divFits  = (w_divShift >= {1'b0, r_opnd});
        if (r_op[1]) begin
            w_nextHi = w_divFits ? w_divDiff : w_divShift[W-1:0];
            w_nextLo = {r_lo[W-2:0], w_divFits};
        end else begin
            w_nextHi = w_mulSum[W:1];
            w_nextLo = {w_mulSum[0], r_lo[W-1:1]};
        end
    end

    // Control FSM plus datapath registers. The write-back values are computed
    // from the last iteration's results so Wen rises in the WB cycle itself.
    // A zero divisor is not special-cased: the restoring algorithm yields an
    // all-ones quotient and the dividend as remainder on its own.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_dest  <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            Busy    <= 1'b0;
            Wen     <= 1'b0;
            Wd      <= '0;
            Wdat    <= '0;
            DivZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_op    <= Op;
                        r_dest  <= Dest;
                        r_count <= '0;
                        r_hi    <= '0;
                        r_lo    <= Op[1] ? OpA : OpB;
                        r_opnd  <= Op[1] ? OpB : OpA;
                        DivZero <= 1'b0;
                        Busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_hi    <= w_nextHi;
                    r_lo    <= w_nextLo;
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(W - 1)) begin
                        Wen     <= 1'b1;
                        Wd      <= r_dest;
                        Wdat    <= r_op[0] ? w_nextHi : w_nextLo;
                        DivZero <= r_op[1] && (r_opnd == '0);
                        r_state <= WB;
                    end
                end
                WB: begin
                    Wen     <= 1'b0;
                    Busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Directed testbench for mul_div_unit. Inputs change on the falling clock
// edge and outputs are sampled on the falling edge, away from the active
// rising edge. Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [1:0] Op;
    logic [7:0] OpA;
    logic [7:0] OpB;
    logic [2:0] Dest;
    logic       Busy;
    logic       Wen;
    logic [2:0] Wd;
    logic [7:0] Wdat;
    logic       DivZero;

    int assertCount = 0;
    int failCount   = 0;

    mul_div_unit #(.W(8), .AW(3)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .OpA     (OpA),
        .OpB     (OpB),
        .Dest    (Dest),
        .Busy    (Busy),
        .Wen     (Wen),
        .Wd      (Wd),
        .Wdat    (Wdat),
        .DivZero (DivZero)
    );

    // 10 time-unit clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present an issue request; called on a falling edge
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [2:0] dest);
        Start = 1'b1;
        Op    = op;
        OpA   = a;
        OpB   = b;
        Dest  = dest;
    endtask

    // Issue one op, scramble the operands after acceptance, and follow it
    // through ten rising edges (E0..E9), checking Busy, the single Wen pulse
    // after E8, its address/data, and DivZero at and after write-back.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] dest,
                         input logic [7:0] expData, input logic expDz);
        int wenCount  = 0;
        int wenCycle  = -1;
        int busyCount = 0;
        logic [2:0] gotWd = '0;
        logic [7:0] gotWdat = '0;
        logic gotDz = 1'b0;
        applyStimulus(op, a, b, dest);
        for (int k = 0; k <= 9; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (k == 0) begin
                checkOutput({tag, " DivZero cleared on accept"}, 32'(DivZero), 32'(1'b0));
                Start = 1'b0;
                OpA   = ~OpA;
                OpB   = OpB ^ 8'h5A;
                Dest  = ~Dest;
            end
            if (Busy) busyCount++;
            if (Wen) begin
                wenCount++;
                wenCycle = k;
                gotWd    = Wd;
                gotWdat  = Wdat;
                gotDz    = DivZero;
            end
            if (k == 9) begin
                checkOutput({tag, " Busy low after WB"}, 32'(Busy), 32'(1'b0));
                checkOutput({tag, " DivZero held after WB"}, 32'(DivZero), 32'(expDz));
            end
        end
        checkOutput({tag, " busy cycles"}, 32'(busyCount), 32'd9);
        checkOutput({tag, " Wen count"}, 32'(wenCount), 32'd1);
        checkOutput({tag, " Wen cycle"}, 32'(wenCycle), 32'd8);
        checkOutput({tag, " Wd"}, 32'(gotWd), 32'(dest));
        checkOutput({tag, " Wdat"}, 32'(gotWdat), 32'(expData));
        checkOutput({tag, " DivZero at WB"}, 32'(gotDz), 32'(expDz));
    endtask

    // Main sequence of directed tests
    initial begin
        int wenSeen;
        Reset = 1'b0;
        Start = 1'b0;
        Op    = 2'b00;
        OpA   = 8'h00;
        OpB   = 8'h00;
        Dest  = 3'd0;

        // Reset held low for two edges
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checkOutput("reset Busy", 32'(Busy), 32'd0);
        checkOutput("reset Wen", 32'(Wen), 32'd0);
        checkOutput("reset Wd", 32'(Wd), 32'd0);
        checkOutput("reset Wdat", 32'(Wdat), 32'd0);
        checkOutput("reset DivZero", 32'(DivZero), 32'd0);
        Reset = 1'b1;

        // Multiply: 12*10 = 0x78; 255*255 = 0xFE01
        runOp("mullo 12x10", 2'b00, 8'h0C, 8'h0A, 3'd3, 8'h78, 1'b0);
        runOp("mulhi FFxFF", 2'b01, 8'hFF, 8'hFF, 3'd5, 8'hFE, 1'b0);
        runOp("mullo FFxFF", 2'b00, 8'hFF, 8'hFF, 3'd5, 8'h01, 1'b0);

        // Divide: 200 / 7 = 28 rem 4
        runOp("divq 200/7", 2'b10, 8'hC8, 8'h07, 3'd1, 8'h1C, 1'b0);
        runOp("divr 200/7", 2'b11, 8'hC8, 8'h07, 3'd1, 8'h04, 1'b0);

        // Divide by zero: all-ones quotient, dividend as remainder, sticky flag
        runOp("divq 42/0", 2'b10, 8'h2A, 8'h00, 3'd6, 8'hFF, 1'b1);
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("DivZero sticky in idle", 32'(DivZero), 32'd1);
        runOp("divr 42/0", 2'b11, 8'h2A, 8'h00, 3'd7, 8'h2A, 1'b1);
        runOp("mullo after div0", 2'b00, 8'h03, 8'h05, 3'd2, 8'h0F, 1'b0);

        // Start held high: only edges 0 and 10 are accepted
        wenSeen = 0;
        for (int i = 0; i < 20; i++) begin
            Start = 1'b1;
            Op    = 2'b00;
            OpA   = 8'(i + 1);
            OpB   = (i == 0 || i == 10) ? 8'h03 : (8'hF0 ^ 8'(i));
            Dest  = 3'(i);
            @(posedge Clk);
            @(negedge Clk);
            if (Wen) wenSeen++;
            if (i == 8) begin
                checkOutput("held start op1 Wen", 32'(Wen), 32'd1);
                checkOutput("held start op1 Wd", 32'(Wd), 32'd0);
                checkOutput("held start op1 Wdat", 32'(Wdat), 32'h03);
            end
            if (i == 9)
                checkOutput("held start Busy low after op1", 32'(Busy), 32'd0);
            if (i == 10)
                checkOutput("held start Busy after reissue", 32'(Busy), 32'd1);
            if (i == 18) begin
                checkOutput("held start op2 Wen", 32'(Wen), 32'd1);
                checkOutput("held start op2 Wd", 32'(Wd), 32'd2);
                checkOutput("held start op2 Wdat", 32'(Wdat), 32'h21);
            end
        end
        Start = 1'b0;
        checkOutput("held start Wen count", 32'(wenSeen), 32'd2);
        @(posedge Clk);
        @(negedge Clk);

        // Reset during a divide abandons it
        applyStimulus(2'b10, 8'h64, 8'h03, 3'd4);
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checkOutput("mid reset Busy", 32'(Busy), 32'd0);
        checkOutput("mid reset Wen", 32'(Wen), 32'd0);
        checkOutput("mid reset Wd", 32'(Wd), 32'd0);
        checkOutput("mid reset Wdat", 32'(Wdat), 32'd0);
        checkOutput("mid reset DivZero", 32'(DivZero), 32'd0);
        Reset = 1'b1;
        wenSeen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Wen || Busy) wenSeen++;
        end
        checkOutput("no activity after mid reset", 32'(wenSeen), 32'd0);
        runOp("divr 101/10 after reset", 2'b11, 8'h65, 8'h0A, 3'd4, 8'h01, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle unsigned multiply/divide execution unit. It sits between the register file read ports and the register file write port. It consumes two 8-bit operands read from the register file, iterates for a fixed number of cycles, then drives a single-cycle write-back (Wen/Wd/Wdat) into the register file. Only one operation is in flight at a time; a Start/Busy handshake controls issue.

Parameters:
W, 8, operand/result data width; must match register file word width
AW, 3, register address width (8 registers)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous reset, active-low (Reset==0 resets on rising Clk)
Start  input  1  issue request; sampled only when Busy==0
Op  input  2  00 MULLO, 01 MULHI, 10 DIVQ (quotient), 11 DIVR (remainder)
OpA  input  W  multiplicand / dividend (register file RdatA)
OpB  input  W  multiplier / divisor (register file RdatB)
Dest  input  AW  destination register for the result
Busy  output  1  high from the cycle after accepted Start through the write-back cycle
Wen  output  1  write-enable pulse to register file, exactly one cycle per operation
Wd  output  AW  write address, valid while Wen==1
Wdat  output  W  write data, valid while Wen==1
DivZero  output  1  sticky flag, set at write-back of a DIVQ/DIVR with OpB==0; cleared on next accepted Start

Behaviour:
- Reset==0 at a rising edge: state IDLE, Busy=0, Wen=0, Wd=0, Wdat=0, DivZero=0, counter=0, internal operand/accumulator registers=0. Reset has priority over everything.
- Reset mid-operation: operation abandoned, no Wen pulse, outputs return to reset values next cycle.
- States: IDLE, RUN, WB.
- IDLE: if Start==1 at edge E0, latch OpA, OpB, Op, Dest; clear counter and accumulators; clear DivZero; go RUN. Otherwise stay. Busy=0.
- RUN: one iteration per edge, W iterations total (edges E1..E8 for W=8). Busy=1. Start ignored. Input operand changes are ignored after latch.
  - MUL: shift-add, 2W-bit unsigned product; each step adds the multiplicand if the current multiplier LSB is 1, then shifts.
  - DIV: restoring division, W-bit quotient and W-bit remainder; each step shifts the partial remainder in, trial-subtracts the divisor, keeps the result if non-negative and sets the quotient bit.
  - After the W-th iteration go WB.
- WB: one cycle. Wen=1, Wd=latched Dest, Wdat selected by Op:
  - MULLO: product[W-1:0]
  - MULHI: product[2W-1:W]
  - DIVQ: quotient
  - DIVR: remainder
  - Busy=1 and Start ignored during WB. Next edge: go IDLE, Wen=0.
- Latency: Start sampled at E0 -> Wen high in the cycle after E8 -> register file captures at E9. Fixed W+1 cycles for every Op, including divide-by-zero.
- Earliest re-issue: Start sampled at the edge ending WB is ignored; the first accepted Start is in the IDLE cycle after WB.
- Divide by zero (latched OpB==0, Op=DIVQ/DIVR): no early exit. Result is quotient=all ones (0xFF) and remainder=OpA, which is what the restoring algorithm naturally produces. DivZero set in the WB cycle and held until the next accepted Start or reset.
- Wd and Wdat hold their last values when Wen==0; consumers must qualify them with Wen.
- All arithmetic is unsigned; no overflow flag. MULHI plus MULLO give the full 16-bit product.

Test Plan:
1. Reset held low 2 cycles, then Start=1, Op=00, OpA=0x0C, OpB=0x0A, Dest=3 -> Busy high 9 cycles; Wen pulse exactly once, at cycle 9 after E0, with Wd=3, Wdat=0x78.
2. Op=01, OpA=0xFF, OpB=0xFF, Dest=5 -> Wdat=0xFE (product 0xFE01); rerun with Op=00 -> Wdat=0x01.
3. Op=10 then Op=11, OpA=0xC8 (200), OpB=0x07, Dest=1 -> Wdat=0x1C (28), then 0x04; DivZero stays 0.
4. Op=10, OpA=0x2A, OpB=0x00 -> Wdat=0xFF, DivZero=1 from the WB cycle onward; next Start with Op=00 clears DivZero on acceptance.
5. Start held high continuously with differing OpA/Dest each cycle -> only the operands at accepted edges are used; OpA/OpB changes during RUN have no effect; ops complete back-to-back every 10 cycles with one Wen per op.
6. Start a DIV, drive Reset=0 at RUN iteration 4 -> no Wen pulse; Busy=0 and outputs at reset values the next cycle; an op issued after Reset returns high completes normally.
